// File: rtl/shift_pkg.sv
// Shared types and constants for the shifter arbiter and its barrel shifter.
package shift_pkg;

    localparam int SHIFT_W = 32'd32;
    localparam int SHAMT_W = 32'd5;

    // One shift request as seen by the shared shifter.
    typedef struct packed {
        logic [SHIFT_W-1:0] opranda;
        logic [SHAMT_W-1:0] oprandb;
        logic               right_flag;
        logic               right_arith_flag;
    } shift_req_t;

    // Result slot occupancy; rsp_valid is simply "slot is FULL".
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Mirror a word end for end so one right-shift network also serves left shifts.
    function automatic logic [SHIFT_W-1:0] bit_reverse(input logic [SHIFT_W-1:0] d);
        logic [SHIFT_W-1:0] r;
        r = '0;
        for (int i = 0; i < SHIFT_W; i++) begin
            r[i] = d[SHIFT_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_shifter_optimized.sv
// Combinational 32-bit barrel shifter: left, logical right, arithmetic right.
// A single log2 right-shift network is used; left shifts are done by
// bit-reversing the operand on the way in and the result on the way out.
module barrel_shifter_optimized
    import shift_pkg::*;
(
    input  shift_req_t         req,
    output logic [SHIFT_W-1:0] res
);

    logic               fill_s;
    logic [SHIFT_W-1:0] stage_s;

    // Fill bit: sign for arithmetic right, zero otherwise (arith ignored on left).
    always_comb begin
        fill_s = req.right_flag & req.right_arith_flag & req.opranda[SHIFT_W-1];
    end

    // Five conditional stages of 1, 2, 4, 8, 16 positions each.
    always_comb begin
        if (req.right_flag) begin
            stage_s = req.opranda;
        end else begin
            stage_s = bit_reverse(req.opranda);
        end
        for (int i = 0; i < SHAMT_W; i++) begin
            if (req.oprandb[i]) begin
                stage_s = (stage_s >> (1 << i))
                        | (fill_s ? ~({SHIFT_W{1'b1}} >> (1 << i)) : {SHIFT_W{1'b0}});
            end else begin
                stage_s = stage_s;
            end
        end
        if (req.right_flag) begin
            res = stage_s;
        end else begin
            res = bit_reverse(stage_s);
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of one shared barrel shifter with a
// single registered result slot. Port 0: ALU shifts, port 1: load/store
// byte alignment. Results carry the issuing port id and its tag.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [SHIFT_W-1:0] req0_opranda,
    input  logic [SHAMT_W-1:0] req0_oprandb,
    input  logic               req0_right_flag,
    input  logic               req0_right_arith_flag,
    input  logic [TAG_W-1:0]   req0_tag,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [SHIFT_W-1:0] req1_opranda,
    input  logic [SHAMT_W-1:0] req1_oprandb,
    input  logic               req1_right_flag,
    input  logic               req1_right_arith_flag,
    input  logic [TAG_W-1:0]   req1_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [SHIFT_W-1:0] rsp_res,
    output logic               rsp_id,
    output logic [TAG_W-1:0]   rsp_tag
);

    slot_state_t        slot_r;
    logic               ptr_r;
    logic [SHIFT_W-1:0] rsp_res_r;
    logic               rsp_id_r;
    logic [TAG_W-1:0]   rsp_tag_r;

    logic               can_accept_s;
    logic               grant_s;
    logic               fire_s;
    shift_req_t         sel_req_s;
    logic [TAG_W-1:0]   sel_tag_s;
    logic [SHIFT_W-1:0] shift_res_s;

    // Grant and handshake: the slot can take a request when empty or being drained.
    always_comb begin
        can_accept_s = (slot_r == SLOT_EMPTY) | rsp_ready;
        if (req0_valid & req1_valid) begin
            grant_s = ptr_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else if (req0_valid) begin
            grant_s = 1'b0;
        end else begin
            grant_s = ptr_r;
        end
        req0_ready = can_accept_s & ~grant_s;
        req1_ready = can_accept_s &  grant_s;
        fire_s     = can_accept_s & (grant_s ? req1_valid : req0_valid);
    end

    // Route the granted port's payload to the shared shifter.
    always_comb begin
        if (grant_s) begin
            sel_req_s.opranda          = req1_opranda;
            sel_req_s.oprandb          = req1_oprandb;
            sel_req_s.right_flag       = req1_right_flag;
            sel_req_s.right_arith_flag = req1_right_arith_flag;
            sel_tag_s                  = req1_tag;
        end else begin
            sel_req_s.opranda          = req0_opranda;
            sel_req_s.oprandb          = req0_oprandb;
            sel_req_s.right_flag       = req0_right_flag;
            sel_req_s.right_arith_flag = req0_right_arith_flag;
            sel_tag_s                  = req0_tag;
        end
    end

    barrel_shifter_optimized u_shifter (
        .req (sel_req_s),
        .res (shift_res_s)
    );

    // Result slot and round-robin pointer; pointer moves to the loser on every fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r    <= SLOT_EMPTY;
            ptr_r     <= 1'b0;
            rsp_res_r <= {SHIFT_W{1'b0}};
            rsp_id_r  <= 1'b0;
            rsp_tag_r <= {TAG_W{1'b0}};
        end else if (fire_s) begin
            slot_r    <= SLOT_FULL;
            ptr_r     <= ~grant_s;
            rsp_res_r <= shift_res_s;
            rsp_id_r  <= grant_s;
            rsp_tag_r <= sel_tag_s;
        end else if (rsp_ready) begin
            slot_r    <= SLOT_EMPTY;
        end else begin
            slot_r    <= slot_r;
        end
    end

    assign rsp_valid = (slot_r == SLOT_FULL);
    assign rsp_res   = rsp_res_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_tag   = rsp_tag_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed table, corner sequences,
// and randomized traffic against a behavioural reference model.
module tb_shift_arbiter;

    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req0_ready, req0_right_flag, req0_right_arith_flag;
    logic [31:0]       req0_opranda;
    logic [4:0]        req0_oprandb;
    logic [TAG_W-1:0]  req0_tag;
    logic              req1_valid, req1_ready, req1_right_flag, req1_right_arith_flag;
    logic [31:0]       req1_opranda;
    logic [4:0]        req1_oprandb;
    logic [TAG_W-1:0]  req1_tag;
    logic              rsp_valid, rsp_ready, rsp_id;
    logic [31:0]       rsp_res;
    logic [TAG_W-1:0]  rsp_tag;

    int n_checks = 0;
    int n_pass   = 0;

    shift_arbiter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_opranda(req0_opranda), .req0_oprandb(req0_oprandb),
        .req0_right_flag(req0_right_flag), .req0_right_arith_flag(req0_right_arith_flag),
        .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_opranda(req1_opranda), .req1_oprandb(req1_oprandb),
        .req1_right_flag(req1_right_flag), .req1_right_arith_flag(req1_right_arith_flag),
        .req1_tag(req1_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference shift straight from the operator semantics.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] b,
                                              input logic r, input logic ar);
        logic signed [31:0] sa;
        sa = a;
        if (!r) return a << b;
        else if (ar) return 32'(sa >>> b);
        else return a >> b;
    endfunction

    task automatic set_req(input int port, input logic [31:0] a, input logic [4:0] b,
                           input logic r, input logic ar, input logic [3:0] t);
        if (port == 0) begin
            req0_valid = 1'b1; req0_opranda = a; req0_oprandb = b;
            req0_right_flag = r; req0_right_arith_flag = ar; req0_tag = t;
        end else begin
            req1_valid = 1'b1; req1_opranda = a; req1_oprandb = b;
            req1_right_flag = r; req1_right_arith_flag = ar; req1_tag = t;
        end
    endtask

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [4:0]  b;
        logic        r;
        logic        ar;
        logic [3:0]  t;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        id;
        logic [3:0]  tag;
    } exp_t;

    vec_t        vecs[9];
    exp_t        q[$];
    exp_t        e;
    logic [31:0] pa[2];
    logic [4:0]  pb[2];
    logic        pr[2], par[2], pv[2], fired[2], rdy[2];
    logic [3:0]  pt[2];
    int          wait_cnt[2];
    bit          m_full;
    int          m_ptr, win, w, cyc, txn;
    logic        can;

    initial begin
        vecs[0] = '{0, 32'h80000000, 5'd4,  1'b1, 1'b1, 4'd3,  32'hF8000000};
        vecs[1] = '{1, 32'h1234ABCD, 5'd0,  1'b0, 1'b1, 4'd5,  32'h1234ABCD};
        vecs[2] = '{0, 32'h00000001, 5'd31, 1'b0, 1'b0, 4'd1,  32'h80000000};
        vecs[3] = '{1, 32'hFFFFFFFF, 5'd31, 1'b1, 1'b0, 4'd2,  32'h00000001};
        vecs[4] = '{0, 32'h80000000, 5'd31, 1'b1, 1'b1, 4'd15, 32'hFFFFFFFF};
        vecs[5] = '{1, 32'h7FFFFFFF, 5'd31, 1'b1, 1'b1, 4'd6,  32'h00000000};
        vecs[6] = '{0, 32'hF0F0F0F0, 5'd8,  1'b0, 1'b1, 4'd9,  32'hF0F0F000};
        vecs[7] = '{1, 32'hF0F0F0F0, 5'd8,  1'b1, 1'b0, 4'd10, 32'h00F0F0F0};
        vecs[8] = '{0, 32'h80000000, 5'd0,  1'b1, 1'b1, 4'd0,  32'h80000000};

        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_opranda = 32'd0; req0_oprandb = 5'd0;
        req0_right_flag = 1'b0; req0_right_arith_flag = 1'b0; req0_tag = 4'd0;
        req1_valid = 1'b0; req1_opranda = 32'd0; req1_oprandb = 5'd0;
        req1_right_flag = 1'b0; req1_right_arith_flag = 1'b0; req1_tag = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_res",   rsp_res,        32'd0);
        check("reset_id",    32'(rsp_id),    32'd0);
        check("reset_tag",   32'(rsp_tag),   32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed table: one request at a time, result one cycle later.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
            set_req(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].ar, vecs[i].t);
            @(negedge clk);
            check("tbl_ready", 32'((vecs[i].port == 0) ? req0_ready : req1_ready), 32'd1);
            @(posedge clk); #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            @(negedge clk);
            check("tbl_valid", 32'(rsp_valid), 32'd1);
            check("tbl_res",   rsp_res, vecs[i].exp);
            check("tbl_id",    32'(rsp_id), 32'(vecs[i].port));
            check("tbl_tag",   32'(rsp_tag), 32'(vecs[i].t));
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("tbl_drained", 32'(rsp_valid), 32'd0);

        // Reset while the slot is FULL and stalled.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(0, 32'h00000005, 5'd1, 1'b0, 1'b0, 4'd7);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("mid_full", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_res",   rsp_res,        32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Contention after reset: port 0 first, then strict alternation.
        rsp_ready = 1'b1;
        set_req(0, 32'h00000001, 5'd31, 1'b0, 1'b0, 4'd1);
        set_req(1, 32'hFFFFFFFF, 5'd31, 1'b1, 1'b0, 4'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) begin
                check("alt_ready0", 32'(req0_ready), 32'((k % 2) == 0));
                check("alt_ready1", 32'(req1_ready), 32'((k % 2) == 1));
            end
            if (k > 0) begin
                check("alt_valid", 32'(rsp_valid), 32'd1);
                check("alt_id",    32'(rsp_id), 32'((k - 1) % 2));
                check("alt_res",   rsp_res, ((k - 1) % 2 == 0) ? 32'h80000000 : 32'h00000001);
                check("alt_tag",   32'(rsp_tag), ((k - 1) % 2 == 0) ? 32'd1 : 32'd2);
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure: FULL and stalled for 5 cycles with both ports waiting.
        rsp_ready = 1'b0;
        set_req(0, 32'h00000003, 5'd1, 1'b0, 1'b0, 4'd4);
        @(posedge clk); #1;
        set_req(0, 32'h00000010, 5'd4, 1'b0, 1'b0, 4'd7);
        set_req(1, 32'h00000100, 5'd4, 1'b1, 1'b0, 4'd8);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("bp_ready0", 32'(req0_ready), 32'd0);
            check("bp_ready1", 32'(req1_ready), 32'd0);
            check("bp_valid",  32'(rsp_valid), 32'd1);
            check("bp_res",    rsp_res, 32'h00000006);
            check("bp_id",     32'(rsp_id), 32'd0);
            check("bp_tag",    32'(rsp_tag), 32'd4);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_ready1", 32'(req1_ready), 32'd1);
        check("bp_rel_ready0", 32'(req0_ready), 32'd0);
        check("bp_rel_res",    rsp_res, 32'h00000006);
        @(posedge clk); #1 req1_valid = 1'b0;
        @(negedge clk);
        check("bp_r1_res",   rsp_res, 32'h00000010);
        check("bp_r1_id",    32'(rsp_id), 32'd1);
        check("bp_r1_tag",   32'(rsp_tag), 32'd8);
        check("bp_r1_ready0", 32'(req0_ready), 32'd1);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        check("bp_r0_res", rsp_res, 32'h00000100);
        check("bp_r0_id",  32'(rsp_id), 32'd0);
        check("bp_r0_tag", 32'(rsp_tag), 32'd7);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_empty", 32'(rsp_valid), 32'd0);

        // Port 1 alone with shift by 0; pointer must then favour port 0.
        @(posedge clk); #1;
        set_req(1, 32'h1234ABCD, 5'd0, 1'b0, 1'b1, 4'd5);
        @(negedge clk);
        check("p1_ready", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        set_req(0, 32'h00000001, 5'd0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        check("p1_res",    rsp_res, 32'h1234ABCD);
        check("p1_id",     32'(rsp_id), 32'd1);
        check("p1_tag",    32'(rsp_tag), 32'd5);
        check("p1_ptr_r0", 32'(req0_ready), 32'd1);
        check("p1_ptr_r1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Randomized traffic against the reference model.
        m_full = 1'b0; m_ptr = 0; cyc = 0; txn = 0;
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; fired[p] = 1'b0; wait_cnt[p] = 0;
            pa[p] = 32'd0; pb[p] = 5'd0; pr[p] = 1'b0; par[p] = 1'b0; pt[p] = 4'd0;
        end
        while (txn < 10000 && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            for (int p = 0; p < 2; p++) begin
                if (fired[p]) pv[p] = 1'b0;
                fired[p] = 1'b0;
                if (!pv[p] && $urandom_range(0, 99) < 60) begin
                    pv[p]  = 1'b1;
                    pa[p]  = $urandom;
                    pb[p]  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 5'd31 : 5'd0)
                                                         : 5'($urandom_range(0, 31));
                    pr[p]  = 1'($urandom_range(0, 1));
                    par[p] = 1'($urandom_range(0, 1));
                    pt[p]  = 4'($urandom_range(0, 15));
                    wait_cnt[p] = 0;
                end
            end
            set_req(0, pa[0], pb[0], pr[0], par[0], pt[0]);
            set_req(1, pa[1], pb[1], pr[1], par[1], pt[1]);
            req0_valid = pv[0]; req1_valid = pv[1];
            rsp_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            check("rnd_valid", 32'(rsp_valid), 32'(m_full));
            if (m_full) begin
                e = q[0];
                check("rnd_res", rsp_res, e.res);
                check("rnd_id",  32'(rsp_id), 32'(e.id));
                check("rnd_tag", 32'(rsp_tag), 32'(e.tag));
            end
            rdy[0] = req0_ready; rdy[1] = req1_ready;
            can = !m_full || rsp_ready;
            if (pv[0] || pv[1]) begin
                win = (pv[0] && pv[1]) ? m_ptr : (pv[1] ? 1 : 0);
                check("rnd_grant",  32'(rdy[win]), 32'(can));
                check("rnd_loser",  32'(rdy[1 - win]), 32'd0);
            end else begin
                check("rnd_idle_rdy", 32'(rdy[0] & rdy[1]), 32'd0);
            end
            if (m_full && rsp_ready) void'(q.pop_front());
            if ((pv[0] && rdy[0]) || (pv[1] && rdy[1])) begin
                w = (pv[1] && rdy[1]) ? 1 : 0;
                e.res = ref_shift(pa[w], pb[w], pr[w], par[w]);
                e.id  = 1'(w);
                e.tag = pt[w];
                q.push_back(e);
                fired[w] = 1'b1;
                txn++;
                wait_cnt[w] = 0;
                if (pv[1 - w]) begin
                    wait_cnt[1 - w]++;
                    check("rnd_starve", 32'(wait_cnt[1 - w] <= 1), 32'd1);
                end
                m_full = 1'b1;
                m_ptr  = 1 - w;
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
        end
        check("rnd_budget", 32'(txn >= 10000), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit barrel shifter between two requesters: port 0 is execute-stage ALU shift ops, port 1 is the load/store byte-alignment path.
- Round-robin arbitration, valid/ready handshakes on every interface, one registered result slot.
- Sits beside the ALU in the execute stage.
- Response carries the winning port id and a pass-through tag so each requester picks up its own results.

Parameters:
- TAG_W, 4, width of the per-request tag returned unchanged with the result

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle when high with req0_valid
- req0_opranda  in  32  port 0 shift source
- req0_oprandb  in  5  port 0 shift amount
- req0_right_flag  in  1  port 0: 1 = right shift, 0 = left
- req0_right_arith_flag  in  1  port 0: arithmetic right when right_flag=1
- req0_tag  in  TAG_W  port 0 tag
- req1_valid, req1_ready, req1_opranda, req1_oprandb, req1_right_flag, req1_right_arith_flag, req1_tag  same widths and directions as port 0, for port 1
- rsp_valid  out  1  result slot holds a result
- rsp_ready  in  1  consumer takes the result when high with rsp_valid
- rsp_res  out  32  shifted result
- rsp_id  out  1  port that issued the request (0/1)
- rsp_tag  out  TAG_W  tag of that request

Behaviour:
- Reset (async assert, sync deassert by clk): rsp_valid=0, rsp_res=0, rsp_id=0, rsp_tag=0, priority pointer=port 0.
- States, derived from rsp_valid:
  - EMPTY (rsp_valid=0)
  - FULL (rsp_valid=1)
- Accept condition: can_accept = !rsp_valid | rsp_ready, so a full slot being drained this cycle can take a new request (back-to-back throughput of 1/cycle).
- Grant (combinational):
  - Both ports valid: grant goes to the priority pointer port.
  - One port valid: grant goes to that port.
  - reqN_ready = can_accept & grant==N. Never both high in the same cycle.
  - reqN_ready does not depend on reqN_valid of the other port beyond the grant logic; no combinational path from rsp_ready to reqN_ready except through can_accept.
- Transfer (fire) = granted valid & ready:
  - Shifter input muxed from the granted port.
  - Registered next edge: rsp_res, rsp_id, rsp_tag; rsp_valid set to 1.
  - Latency: 1 cycle from accept to rsp_valid.
- Drain without fire: rsp_valid=1 & rsp_ready=1 & no fire clears rsp_valid to 0. rsp_res/id/tag hold their last values.
- Stall: rsp_valid=1 & rsp_ready=0 freezes rsp_* exactly; both readies are 0.
- Priority pointer:
  - Updates only on fire, to the port that did not win.
  - Unchanged when only the pointer port is idle and the other port fires alone? No: the pointer always moves to the non-winner after any fire.
  - Guarantees a waiting port is served within 2 transfers.
- Shift semantics:
  - Left: zero fill.
  - Logical right: zero fill.
  - Arithmetic right: fill with opranda[31].
  - right_arith_flag is ignored when right_flag=0.
  - oprandb=0 returns opranda unchanged.
  - oprandb=31 is valid.
- Requester rules:
  - A requester holds valid and payload stable until ready.
  - The arbiter does not depend on this for correctness; the payload is sampled only at fire.
- Reset mid-operation: any held result is discarded; the pointer returns to 0.

Decomposition:
- Shared package shift_pkg: SHIFT_W=32, SHAMT_W=5, packed typedef shift_req_t {opranda, oprandb, right_flag, right_arith_flag}.
- Sub-module: the existing barrel_shifter_optimized, instantiated once, combinational, between the grant mux and the result register.
- Arbiter grant/pointer logic stays inline; it is too small to split.

Test Plan:
- Reset: assert rst_n=0 mid-FULL -> rsp_valid=0 immediately; after release, first contention grants port 0.
- Port 0 alone, opranda=0x80000000, oprandb=4, right=1, arith=1, tag=3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_res=0xF8000000, rsp_id=0, rsp_tag=3.
- Both valid every cycle, rsp_ready=1: port0 left 0x00000001 by 31, port1 logical right 0xFFFFFFFF by 31 -> grants alternate 0,1,0,1, one result per cycle, results 0x80000000 / 0x00000001.
- Backpressure: FULL with rsp_ready=0 for 5 cycles, both valid -> both readies 0 and rsp_* frozen; on rsp_ready=1, same-cycle accept of the pointer port; no result lost or duplicated.
- Port 1 alone, oprandb=0, arith=1, left (right=0), opranda=0x1234ABCD -> rsp_res=0x1234ABCD; pointer moves to port 0.
- Random 10k transactions with a reference shift model, random valid/ready -> every request returned once with correct id/tag, in accept order, with no port waiting more than 2 transfers under contention.
